// File: rtl/dmadd_sequencer.sv
// rtl/dmadd_sequencer.sv - job sequencer driving a DMADD datapath through clear/init/load/run/capture
module dmadd_sequencer #(
    parameter int MAX_ITEMS  = 16,
    parameter int RUN_CYCLES = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic        item_valid,
    output logic        item_ready,
    input  logic [3:0]  item_index,
    input  logic [3:0]  item_data,
    input  logic        item_last,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [11:0] result,
    output logic        busy,
    output logic        err,
    output logic        dm_rst_n,
    output logic        dm_load,
    output logic        dm_run,
    output logic [1:0]  dm_insn,
    output logic [3:0]  dm_index,
    output logic [3:0]  dm_data,
    input  logic [7:0]  dm_out,
    input  logic [3:0]  dm_out_top
);

    localparam int CNT_W = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;
    localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_ITEM = CNT_W'(MAX_ITEMS - 1);
    localparam logic [RUN_W-1:0] LAST_RUN  = RUN_W'(RUN_CYCLES - 1);
    localparam logic [1:0] MODE_MADD = 2'b10;
    localparam logic [1:0] MODE_BAD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_INIT, S_LOAD, S_RUN, S_CAPTURE, S_RESP
    } state_t;

    state_t           r_state;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_items;
    logic [RUN_W-1:0] r_run_cnt;
    logic [11:0]      r_result;
    logic             r_result_valid;
    logic             r_item_ready;
    logic             r_busy;
    logic             r_err;
    logic             r_dm_rst_n;
    logic             r_dm_run;
    logic [1:0]       r_dm_insn;
    logic             w_load;

    // Item_ready is only ever high in LOAD, so it doubles as the LOAD qualifier.
    assign w_load = r_item_ready && item_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_mode         <= 2'b00;
            r_items        <= '0;
            r_run_cnt      <= '0;
            r_result       <= 12'h000;
            r_result_valid <= 1'b0;
            r_item_ready   <= 1'b0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
            r_dm_rst_n     <= 1'b0;
            r_dm_run       <= 1'b0;
            r_dm_insn      <= 2'b00;
        end else begin
            r_dm_rst_n <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start && mode == MODE_BAD) begin
                        r_err <= 1'b1;
                    end else if (start) begin
                        r_mode     <= mode;
                        r_err      <= 1'b0;
                        r_items    <= '0;
                        r_run_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_dm_rst_n <= 1'b0;
                        r_state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_dm_insn <= r_mode;
                    if (r_mode == MODE_MADD) begin
                        r_item_ready <= 1'b1;
                        r_state      <= S_LOAD;
                    end else begin
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_item_ready <= 1'b1;
                    r_state      <= S_LOAD;
                end
                S_LOAD: begin
                    if (item_valid) begin
                        r_items <= r_items + 1'b1;
                        if (item_last || r_items == LAST_ITEM) begin
                            if (!item_last)
                                r_err <= 1'b1;
                            r_item_ready <= 1'b0;
                            r_dm_run     <= 1'b1;
                            r_state      <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_run_cnt <= r_run_cnt + 1'b1;
                    if (r_run_cnt == LAST_RUN) begin
                        r_dm_run <= 1'b0;
                        r_state  <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_result       <= {dm_out_top, dm_out};
                    r_result_valid <= 1'b1;
                    r_dm_insn      <= 2'b00;
                    r_state        <= S_RESP;
                end
                S_RESP: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign item_ready   = r_item_ready;
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign busy         = r_busy;
    assign err          = r_err;
    assign dm_rst_n     = r_dm_rst_n;
    assign dm_run       = r_dm_run;
    assign dm_insn      = r_dm_insn;
    assign dm_load      = w_load;
    assign dm_index     = w_load ? item_index : 4'h0;
    assign dm_data      = w_load ? item_data  : 4'h0;

endmodule

// File: tb/tb_dmadd_sequencer.sv
// tb/tb_dmadd_sequencer.sv - randomized and directed bench for dmadd_sequencer
module tb_dmadd_sequencer;

    localparam int RUNC = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        item_valid = 1'b0;
    logic        item_ready;
    logic [3:0]  item_index = 4'h0;
    logic [3:0]  item_data = 4'h0;
    logic        item_last = 1'b0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [11:0] result;
    logic        busy, err, dm_rst_n, dm_load, dm_run;
    logic [1:0]  dm_insn;
    logic [3:0]  dm_index, dm_data;
    logic [7:0]  dm_out;
    logic [3:0]  dm_out_top;

    int total = 0;
    int bad = 0;

    dmadd_sequencer #(.MAX_ITEMS(16), .RUN_CYCLES(RUNC)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .item_valid(item_valid), .item_ready(item_ready),
        .item_index(item_index), .item_data(item_data), .item_last(item_last),
        .result_valid(result_valid), .result_ready(result_ready), .result(result),
        .busy(busy), .err(err), .dm_rst_n(dm_rst_n), .dm_load(dm_load), .dm_run(dm_run),
        .dm_insn(dm_insn), .dm_index(dm_index), .dm_data(dm_data),
        .dm_out(dm_out), .dm_out_top(dm_out_top)
    );

    always #5 clk = ~clk;

    // Stub datapath: remembers loaded values, answers min/max, fixed pattern for MADD.
    logic [3:0] mem [16];
    logic [15:0] mem_v = '0;
    logic [7:0] madd_out = 8'hA5;
    logic [3:0] madd_top = 4'h3;

    always @(posedge clk) begin
        if (!dm_rst_n) mem_v <= '0;
        else if (dm_load) begin
            mem[dm_index]   <= dm_data;
            mem_v[dm_index] <= 1'b1;
        end
    end

    always_comb begin
        logic [3:0] mn, mx;
        mn = 4'hF;
        mx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (mem_v[i] && mem[i] < mn) mn = mem[i];
            if (mem_v[i] && mem[i] > mx) mx = mem[i];
        end
        dm_out     = 8'h00;
        dm_out_top = 4'h0;
        if (dm_insn == 2'b00) dm_out = {4'h0, mn};
        else if (dm_insn == 2'b01) dm_out = {4'h0, mx};
        else if (dm_insn == 2'b10) begin
            dm_out     = madd_out;
            dm_out_top = madd_top;
        end
    end

    // Per-job phase counters observed on the falling edge.
    int n_clear, n_gap, n_load, n_run, n_insn_bad;
    logic [1:0] cur_mode;

    always @(negedge clk) begin
        if (busy && !dm_rst_n) n_clear++;
        if (busy && dm_rst_n && !item_ready && !dm_run && !result_valid) n_gap++;
        if (dm_load) n_load++;
        if (dm_run) n_run++;
        if ((item_ready || dm_run) && dm_insn !== cur_mode) n_insn_bad++;
        if (!busy && dm_insn !== 2'b00) n_insn_bad++;
        if (dm_load && !item_ready) n_insn_bad++;
    end

    logic [3:0] job_data [16];
    logic [11:0] last_result = 12'h000;

    task automatic do_job(input logic [1:0] m, input int n, input bit use_last,
                          input int gap_max, input int rdy_dly, input string tag);
        logic [11:0] exp_res;
        logic [3:0]  mn, mx;
        bit          rdy;
        int          bud;
        logic [11:0] held;
        @(posedge clk); #1;
        total++;
        if (result !== last_result) begin
            bad++; $display("FAIL %s result_kept got=%h want=%h", tag, result, last_result);
        end
        n_clear = 0; n_gap = 0; n_load = 0; n_run = 0; n_insn_bad = 0;
        cur_mode = m;
        start = 1'b1; mode = m;
        @(posedge clk); #1;
        start = 1'b0; mode = $urandom_range(3, 0);
        mn = 4'hF; mx = 4'h0;
        for (int i = 0; i < n; i++) begin
            if (job_data[i] < mn) mn = job_data[i];
            if (job_data[i] > mx) mx = job_data[i];
            item_valid = 1'b0;
            repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
            item_valid = 1'b1; item_index = i[3:0]; item_data = job_data[i];
            item_last = use_last && (i == n - 1);
            bud = 0;
            do begin
                @(negedge clk); rdy = item_ready;
                @(posedge clk); #1; bud++;
            end while (!rdy && bud < 50);
            if (!rdy) begin
                total++; bad++;
                $display("FAIL %s item_timeout idx=%0d", tag, i);
                item_valid = 1'b0;
                return;
            end
        end
        item_valid = 1'b0; item_last = 1'b0;
        @(negedge clk);
        total++;
        if (item_ready !== 1'b0) begin
            bad++; $display("FAIL %s ready_after_last got=%b want=0", tag, item_ready);
        end
        bud = 0;
        while (!result_valid && bud < 100) begin @(negedge clk); bud++; end
        total++;
        if (!result_valid) begin
            bad++; $display("FAIL %s result_timeout", tag);
            return;
        end
        exp_res = (m == 2'b00) ? {8'h00, mn} : (m == 2'b01) ? {8'h00, mx} : {madd_top, madd_out};
        total++;
        if (result !== exp_res) begin bad++; $display("FAIL %s result got=%h want=%h", tag, result, exp_res); end
        total++;
        if (n_clear !== 1) begin bad++; $display("FAIL %s clear_cycles got=%0d want=1", tag, n_clear); end
        total++;
        if (n_gap !== ((m == 2'b10) ? 1 : 2)) begin
            bad++; $display("FAIL %s init_capture_cycles got=%0d want=%0d", tag, n_gap, (m == 2'b10) ? 1 : 2);
        end
        total++;
        if (n_load !== n) begin bad++; $display("FAIL %s load_pulses got=%0d want=%0d", tag, n_load, n); end
        total++;
        if (n_run !== RUNC) begin bad++; $display("FAIL %s run_cycles got=%0d want=%0d", tag, n_run, RUNC); end
        total++;
        if (n_insn_bad !== 0) begin bad++; $display("FAIL %s insn_violations got=%0d want=0", tag, n_insn_bad); end
        total++;
        if (err !== !use_last) begin bad++; $display("FAIL %s err got=%b want=%b", tag, err, !use_last); end
        held = result;
        repeat (rdy_dly) begin
            @(posedge clk); #1;
            @(negedge clk);
            total++;
            if (result_valid !== 1'b1 || result !== held) begin
                bad++; $display("FAIL %s resp_hold valid=%b result=%h want=1/%h", tag, result_valid, result, held);
            end
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            bad++; $display("FAIL %s after_handshake busy=%b valid=%b want=0/0", tag, busy, result_valid);
        end
        last_result = exp_res;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({busy, err, result_valid, item_ready, dm_rst_n, dm_load, dm_run, dm_insn, dm_index, dm_data, result} !== 32'h0) begin
            bad++; $display("FAIL reset_outputs busy=%b err=%b rv=%b rdy=%b rstn=%b result=%h", busy, err, result_valid, item_ready, dm_rst_n, result);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        total++;
        if (dm_rst_n !== 1'b0) begin bad++; $display("FAIL reset_rstn_hold got=%b want=0", dm_rst_n); end
        @(posedge clk); #1;
        total++;
        if (dm_rst_n !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_release rstn=%b busy=%b want=1/0", dm_rst_n, busy);
        end
    endtask

    task automatic test_min();
        job_data[0] = 4'd5; job_data[1] = 4'd9;
        do_job(2'b00, 2, 1'b1, 0, 0, "min");
    endtask

    task automatic test_max();
        job_data[0] = 4'd5; job_data[1] = 4'd9;
        do_job(2'b01, 2, 1'b1, 1, 2, "max");
    endtask

    task automatic test_madd();
        madd_out = 8'hA5; madd_top = 4'h3;
        job_data[0] = 4'd7; job_data[1] = 4'd2; job_data[2] = 4'd11;
        do_job(2'b10, 3, 1'b1, 0, 1, "madd");
    endtask

    task automatic test_illegal();
        @(posedge clk); #1;
        start = 1'b1; mode = 2'b11;
        @(posedge clk); #1;
        start = 1'b0; mode = 2'b00;
        repeat (5) begin
            @(negedge clk);
            total++;
            if (err !== 1'b1 || busy !== 1'b0 || dm_rst_n !== 1'b1 || dm_load !== 1'b0 || dm_run !== 1'b0 || dm_insn !== 2'b00) begin
                bad++; $display("FAIL illegal err=%b busy=%b rstn=%b load=%b run=%b insn=%b", err, busy, dm_rst_n, dm_load, dm_run, dm_insn);
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) job_data[i] = 4'($urandom_range(15, 0));
        do_job(2'b01, 16, 1'b0, 1, 0, "overflow");
    endtask

    task automatic test_rst_mid_run();
        int bud;
        @(posedge clk); #1;
        n_run = 0; cur_mode = 2'b00;
        start = 1'b1; mode = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        item_valid = 1'b1; item_index = 4'd0; item_data = 4'd3; item_last = 1'b1;
        bud = 0;
        while (n_run < 8 && bud < 60) begin
            @(negedge clk); bud++;
            if (item_ready) begin @(posedge clk); #1; item_valid = 1'b0; item_last = 1'b0; end
        end
        item_valid = 1'b0; item_last = 1'b0;
        total++;
        if (n_run < 8) begin bad++; $display("FAIL rst_run_reach got=%0d want=8", n_run); end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, err, result_valid, item_ready, dm_rst_n, dm_load, dm_run, dm_insn, dm_index, dm_data, result} !== 32'h0) begin
            bad++; $display("FAIL rst_async busy=%b rv=%b rstn=%b run=%b insn=%b result=%h want all 0", busy, result_valid, dm_rst_n, dm_run, dm_insn, result);
        end
        @(negedge clk); rst = 1'b0;
        last_result = 12'h000;
        bud = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid || busy) bud++;
        end
        total++;
        if (bud !== 0) begin bad++; $display("FAIL rst_abandon active_cycles got=%0d want=0", bud); end
    endtask

    task automatic test_random();
        for (int j = 0; j < 10; j++) begin
            int n;
            n = $urandom_range(16, 1);
            madd_out = 8'($urandom); madd_top = 4'($urandom);
            for (int i = 0; i < 16; i++) job_data[i] = 4'($urandom_range(15, 0));
            do_job(2'($urandom_range(2, 0)), n, 1'b1, $urandom_range(2, 0), $urandom_range(3, 0), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 3; j++) begin
            job_data[0] = 4'($urandom_range(15, 0));
            job_data[1] = 4'($urandom_range(15, 0));
            do_job(2'(j), 2, 1'b1, 0, 0, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_min();
        test_max();
        test_madd();
        test_illegal();
        test_min();
        test_overflow();
        test_rst_mid_run();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
